// File: rtl/div_seg_scan.sv
// div_seg_scan: captures a 4-bit divider result (quotient, remainder,
// divide-by-zero flag) and multiplexes it onto a 4-digit common-anode
// 7-segment display. A prescaler sets how long each digit is lit. A
// one-cycle frame pulse marks the end of every complete 4-digit scan.
module div_seg_scan #(
    parameter int REFRESH_DIV = 4096
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] q,
    input  logic [3:0] r,
    input  logic [3:0] dsr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame
);

    // The prescaler must hold REFRESH_DIV-1. Keep it at least 1 bit wide.
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TC_VAL   = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_DASH    = 7'h3F;
    localparam logic [6:0] SEG_E       = 7'h06;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic          r_valid;
    logic [3:0]    r_qh;
    logic [3:0]    r_rh;
    logic          r_err;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_wrap;
    logic          r_frame;

    logic          w_tc;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_next;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tc = (r_presc == TC_VAL);

    // Select the segment pattern for the digit currently being scanned.
    always_comb begin
        w_seg_next = SEG_BLANK;
        w_an_next  = ~(4'b0001 << r_idx);
        if (!r_valid) begin
            w_seg_next = SEG_BLANK;
        end else if (r_err) begin
            case (r_idx)
                2'd0:    w_seg_next = SEG_DASH;
                2'd1:    w_seg_next = SEG_DASH;
                2'd3:    w_seg_next = SEG_E;
                default: w_seg_next = SEG_BLANK;
            endcase
        end else begin
            case (r_idx)
                2'd0:    w_seg_next = hex7(r_rh);
                2'd1:    w_seg_next = hex7(r_qh);
                default: w_seg_next = SEG_BLANK;
            endcase
        end
    end

    // Prescaler and digit index. Only time moves these, never the inputs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else begin
            if (w_tc) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_idx   <= r_idx;
            end
        end
    end

    // Capture the divider result. The last load strobe wins.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_valid <= 1'b0;
            r_qh    <= 4'h0;
            r_rh    <= 4'h0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_qh    <= q;
            r_rh    <= r;
            r_err   <= (dsr == 4'h0);
        end else begin
            r_valid <= r_valid;
            r_qh    <= r_qh;
            r_rh    <= r_rh;
            r_err   <= r_err;
        end
    end

    // Register the display outputs one cycle behind index and held data.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    // Frame pulse: the cycle after idx wraps 3->0, so it lines up with the
    // first displayed cycle of idx0.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_wrap  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_wrap  <= w_tc && (r_idx == 2'd3);
            r_frame <= r_wrap;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;

endmodule

// File: tb/tb_div_seg_scan.sv
// Directed testbench for div_seg_scan. u_dut4 uses REFRESH_DIV=4 for the
// data and display checks. u_dut2 uses REFRESH_DIV=2 for the frame and
// wrap checks. The variable cyc counts rising edges since the last release
// of clear. With a slot length of N, the digit shown after edge cyc is
// ((cyc-1)/N) mod 4.
module tb_div_seg_scan;

    logic       clk;
    logic       clear;
    logic       load;
    logic [3:0] q;
    logic [3:0] r;
    logic [3:0] dsr;
    logic [6:0] seg4;
    logic [3:0] an4;
    logic       frame4;
    logic [6:0] seg2;
    logic [3:0] an2;
    logic       frame2;

    int n_tests;
    int n_fail;
    int cyc;

    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];

    div_seg_scan #(.REFRESH_DIV(4)) u_dut4 (
        .clk(clk), .clear(clear), .load(load), .q(q), .r(r), .dsr(dsr),
        .seg(seg4), .an(an4), .frame(frame4)
    );

    div_seg_scan #(.REFRESH_DIV(2)) u_dut2 (
        .clk(clk), .clear(clear), .load(1'b0), .q(4'h0), .r(4'h0), .dsr(4'h0),
        .seg(seg2), .an(an2), .frame(frame2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        int slot;
        logic exp_fr;
        clear = 1'b0;
        load  = 1'b0;
        q = 4'h0; r = 4'h0; dsr = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (seg4 !== 7'h7F || an4 !== 4'b1111 || frame4 !== 1'b0 ||
                seg2 !== 7'h7F || an2 !== 4'b1111 || frame2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: seg4=%h an4=%b fr4=%b seg2=%h an2=%b fr2=%b, expected 7f/1111/0",
                         seg4, an4, frame4, seg2, an2, frame2);
            end
        end
        clear = 1'b1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            slot = ((cyc - 1) >> 2) & 3;
            exp_fr = (cyc > 1) && (cyc % 16 == 1);
            n_tests++;
            if (seg4 !== 7'h7F || an4 !== an_tab[slot] || frame4 !== exp_fr) begin
                n_fail++;
                $display("FAIL reset_scan cyc=%0d: seg=%h an=%b fr=%b, expected 7f/%b/%b",
                         cyc, seg4, an4, frame4, an_tab[slot], exp_fr);
            end
        end
    endtask

    task automatic test_normal();
        int slot;
        logic exp_fr;
        // q=3 r=1 dsr=4: idx0 shows '1', idx1 shows '3'
        seg_tab[0] = 7'h79; seg_tab[1] = 7'h30; seg_tab[2] = 7'h7F; seg_tab[3] = 7'h7F;
        load = 1'b1; q = 4'h3; r = 4'h1; dsr = 4'h4;
        step();
        load = 1'b0;
        n_tests++;
        if (seg4 !== 7'h7F || an4 !== 4'b1110) begin
            n_fail++;
            $display("FAIL normal_latency: seg=%h an=%b, expected 7f/1110", seg4, an4);
        end
        while (cyc < 32) begin
            step();
            slot = ((cyc - 1) >> 2) & 3;
            exp_fr = (cyc % 16 == 1);
            n_tests++;
            if (seg4 !== seg_tab[slot] || an4 !== an_tab[slot] || frame4 !== exp_fr) begin
                n_fail++;
                $display("FAIL normal cyc=%0d: seg=%h an=%b fr=%b, expected %h/%b/%b",
                         cyc, seg4, an4, frame4, seg_tab[slot], an_tab[slot], exp_fr);
            end
        end
    endtask

    task automatic test_div_zero();
        int slot;
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h3F; seg_tab[2] = 7'h7F; seg_tab[3] = 7'h06;
        load = 1'b1; q = 4'h5; r = 4'h7; dsr = 4'h0;
        step();
        load = 1'b0;
        n_tests++;
        if (seg4 !== 7'h79 || an4 !== 4'b1110) begin
            n_fail++;
            $display("FAIL dbz_latency: seg=%h an=%b, expected 79/1110", seg4, an4);
        end
        while (cyc < 48) begin
            step();
            slot = ((cyc - 1) >> 2) & 3;
            n_tests++;
            if (seg4 !== seg_tab[slot] || an4 !== an_tab[slot]) begin
                n_fail++;
                $display("FAIL dbz cyc=%0d: seg=%h an=%b, expected %h/%b",
                         cyc, seg4, an4, seg_tab[slot], an_tab[slot]);
            end
        end
    endtask

    task automatic test_coincide();
        int slot;
        seg_tab[0] = 7'h0E; seg_tab[1] = 7'h08; seg_tab[2] = 7'h7F; seg_tab[3] = 7'h7F;
        while (cyc < 51) step();
        // the next edge (52) is the tc edge that leaves idx0
        load = 1'b1; q = 4'hA; r = 4'hF; dsr = 4'h1;
        step();
        load = 1'b0;
        n_tests++;
        if (seg4 !== 7'h3F || an4 !== 4'b1110) begin
            n_fail++;
            $display("FAIL coincide_old: seg=%h an=%b, expected 3f/1110", seg4, an4);
        end
        while (cyc < 68) begin
            step();
            slot = ((cyc - 1) >> 2) & 3;
            n_tests++;
            if (seg4 !== seg_tab[slot] || an4 !== an_tab[slot]) begin
                n_fail++;
                $display("FAIL coincide cyc=%0d: seg=%h an=%b, expected %h/%b",
                         cyc, seg4, an4, seg_tab[slot], an_tab[slot]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int slot;
        seg_tab[0] = 7'h10; seg_tab[1] = 7'h78; seg_tab[2] = 7'h7F; seg_tab[3] = 7'h7F;
        load = 1'b1; q = 4'h1; r = 4'h2; dsr = 4'h3;
        step();
        q = 4'h7; r = 4'h9; dsr = 4'h2;
        step();
        load = 1'b0;
        // edge 70 shows idx1 with the first strobe's quotient (1)
        n_tests++;
        if (seg4 !== 7'h79 || an4 !== 4'b1101) begin
            n_fail++;
            $display("FAIL b2b_first: seg=%h an=%b, expected 79/1101", seg4, an4);
        end
        while (cyc < 86) begin
            step();
            slot = ((cyc - 1) >> 2) & 3;
            n_tests++;
            if (seg4 !== seg_tab[slot] || an4 !== an_tab[slot]) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d: seg=%h an=%b, expected %h/%b",
                         cyc, seg4, an4, seg_tab[slot], an_tab[slot]);
            end
        end
    endtask

    task automatic test_frame();
        int slot;
        int frames;
        logic exp_fr;
        frames = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            slot = ((cyc - 1) >> 1) & 3;
            exp_fr = (cyc > 1) && (cyc % 8 == 1);
            if (frame2 === 1'b1) frames++;
            n_tests++;
            if (frame2 !== exp_fr || an2 !== an_tab[slot] || seg2 !== 7'h7F) begin
                n_fail++;
                $display("FAIL frame2 cyc=%0d: fr=%b an=%b seg=%h, expected %b/%b/7f",
                         cyc, frame2, an2, seg2, exp_fr, an_tab[slot]);
            end
        end
        n_tests++;
        if (frames !== 2) begin
            n_fail++;
            $display("FAIL frame_count: got %0d pulses in 16 cycles, expected 2", frames);
        end
    endtask

    task automatic test_mid_reset();
        int slot;
        int budget;
        logic exp_fr;
        budget = 0;
        while (((((cyc - 1) >> 2) & 3) != 2) && budget < 16) begin
            step();
            budget++;
        end
        n_tests++;
        if (budget >= 16) begin
            n_fail++;
            $display("FAIL midreset_sync: idx2 slot not reached within 16 cycles");
        end
        #2;
        clear = 1'b0;
        #1;
        n_tests++;
        if (seg4 !== 7'h7F || an4 !== 4'b1111 || frame4 !== 1'b0 || an2 !== 4'b1111) begin
            n_fail++;
            $display("FAIL midreset_async: seg=%h an=%b fr=%b an2=%b, expected 7f/1111/0/1111",
                     seg4, an4, frame4, an2);
        end
        #2;
        clear = 1'b1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            slot = ((cyc - 1) >> 2) & 3;
            exp_fr = (cyc > 1) && (cyc % 16 == 1);
            n_tests++;
            if (seg4 !== 7'h7F || an4 !== an_tab[slot] || frame4 !== exp_fr) begin
                n_fail++;
                $display("FAIL midreset_scan cyc=%0d: seg=%h an=%b fr=%b, expected 7f/%b/%b",
                         cyc, seg4, an4, frame4, an_tab[slot], exp_fr);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        clear = 1'b0;
        load  = 1'b0;
        q = 4'h0; r = 4'h0; dsr = 4'h0;
        test_reset();
        test_normal();
        test_div_zero();
        test_coincide();
        test_back_to_back();
        test_frame();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
